// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_engine
//  Description : Rectangle-fill writer for the VGA frame buffer. Accepts one
//                rectangle command per start strobe and emits one pixel write
//                per clock in raster order on the adapter's plot port.
//                Pixels outside COLS x ROWS are clipped (plot low) but still
//                consume their cycle, so latency depends only on w*h.
//                Optional feature macro: RECT_BORDER_EN (adds a one-pixel
//                border drawn in a separate colour).
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_fill_engine #(
  parameter int COLOR_DEPTH = 3,
  parameter int nX          = 8,
  parameter int nY          = 7,
  parameter int COLS        = 160,
  parameter int ROWS        = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [nX-1:0]          x0,
  input  logic [nY-1:0]          y0,
  input  logic [nX-1:0]          w,
  input  logic [nY-1:0]          h,
  input  logic [COLOR_DEPTH-1:0] color,
`ifdef RECT_BORDER_EN
  input  logic                   border,
  input  logic [COLOR_DEPTH-1:0] border_color,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [nX-1:0]          vga_x,
  output logic [nY-1:0]          vga_y,
  output logic [COLOR_DEPTH-1:0] vga_color,
  output logic                   vga_plot
);

  // Clip limits and increments at the widened (no wrap-around) sum width.
  localparam logic [nX:0] c_cols  = (nX+1)'(COLS);
  localparam logic [nY:0] c_rows  = (nY+1)'(ROWS);
  localparam logic [nX:0] c_one_x = (nX+1)'(1);
  localparam logic [nY:0] c_one_y = (nY+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Latched command
  logic [nX-1:0]          x0_q, x0_d;
  logic [nY-1:0]          y0_q, y0_d;
  logic [nX-1:0]          w_q, w_d;
  logic [nY-1:0]          h_q, h_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
`ifdef RECT_BORDER_EN
  logic                   border_q, border_d;
  logic [COLOR_DEPTH-1:0] bcolor_q, bcolor_d;
`endif

  // Index of the pixel currently presented on the outputs
  logic [nX:0] i_q, i_d;
  logic [nY:0] j_q, j_d;

  // Registered outputs
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   plot_q, plot_d;
  logic [nX-1:0]          vx_q, vx_d;
  logic [nY-1:0]          vy_q, vy_d;
  logic [COLOR_DEPTH-1:0] vc_q, vc_d;

  // Decode helpers
  logic                   cmd_empty;
  logic                   last_col;
  logic                   last_row;
  logic                   emit;

  // Next pixel to present, and the command fields it is derived from
  logic [nX-1:0]          src_x0;
  logic [nY-1:0]          src_y0;
  logic [COLOR_DEPTH-1:0] src_color;
`ifdef RECT_BORDER_EN
  logic [nX-1:0]          src_w;
  logic [nY-1:0]          src_h;
  logic                   src_border;
  logic [COLOR_DEPTH-1:0] src_bcolor;
`endif
  logic [nX:0]            pix_i;
  logic [nY:0]            pix_j;
  logic [nX:0]            x_sum;
  logic [nY:0]            y_sum;
  logic                   pix_vis;
  logic [COLOR_DEPTH-1:0] pix_color;

  assign cmd_empty = (w == '0) || (h == '0);
  assign last_col  = (i_q == ({1'b0, w_q} - c_one_x));
  assign last_row  = (j_q == ({1'b0, h_q} - c_one_y));

  // Select which pixel comes next: pixel (0,0) of the incoming command when
  // not drawing, otherwise the raster successor of the current pixel.
  always_comb begin
    src_x0    = x0_q;
    src_y0    = y0_q;
    src_color = color_q;
`ifdef RECT_BORDER_EN
    src_w      = w_q;
    src_h      = h_q;
    src_border = border_q;
    src_bcolor = bcolor_q;
`endif
    pix_i = i_q;
    pix_j = j_q;
    if (state_q != S_DRAW) begin
      src_x0    = x0;
      src_y0    = y0;
      src_color = color;
`ifdef RECT_BORDER_EN
      src_w      = w;
      src_h      = h;
      src_border = border;
      src_bcolor = border_color;
`endif
      pix_i = '0;
      pix_j = '0;
    end else if (last_col) begin
      pix_i = '0;
      pix_j = j_q + c_one_y;
    end else begin
      pix_i = i_q + c_one_x;
    end

    // Sums are one bit wider than the coordinates so that overflow clips
    // instead of wrapping back onto the screen.
    x_sum   = {1'b0, src_x0} + pix_i;
    y_sum   = {1'b0, src_y0} + pix_j;
    pix_vis = (x_sum < c_cols) && (y_sum < c_rows);

    pix_color = src_color;
`ifdef RECT_BORDER_EN
    if (src_border &&
        ((pix_i == '0) || (pix_i == ({1'b0, src_w} - c_one_x)) ||
         (pix_j == '0) || (pix_j == ({1'b0, src_h} - c_one_y)))) begin
      pix_color = src_bcolor;
    end
`endif
  end

  // Next-state and output decode; FINISH behaves like IDLE for accepting.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
`ifdef RECT_BORDER_EN
    border_d = border_q;
    bcolor_d = bcolor_q;
`endif
    i_d    = i_q;
    j_d    = j_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    plot_d = 1'b0;
    vx_d   = vx_q;
    vy_d   = vy_q;
    vc_d   = vc_q;
    emit   = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
`ifdef RECT_BORDER_EN
          border_d = border;
          bcolor_d = border_color;
`endif
          if (cmd_empty) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAW;
            emit    = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (last_col && last_row) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      i_d    = pix_i;
      j_d    = pix_j;
      busy_d = 1'b1;
      plot_d = pix_vis;
      vx_d   = x_sum[nX-1:0];
      vy_d   = y_sum[nY-1:0];
      vc_d   = pix_color;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, counter and output registers; reset aborts any command.
  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
`ifdef RECT_BORDER_EN
      border_q <= 1'b0;
      bcolor_q <= '0;
`endif
      i_q    <= '0;
      j_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      plot_q <= 1'b0;
      vx_q   <= '0;
      vy_q   <= '0;
      vc_q   <= '0;
    end else begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
`ifdef RECT_BORDER_EN
      border_q <= border_d;
      bcolor_q <= bcolor_d;
`endif
      i_q    <= i_d;
      j_q    <= j_d;
      busy_q <= busy_d;
      done_q <= done_d;
      plot_q <= plot_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      vc_q   <= vc_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vga_plot  = plot_q;
  assign vga_x     = vx_q;
  assign vga_y     = vy_q;
  assign vga_color = vc_q;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill_engine
//  Description : Self-checking bench for rect_fill_engine. A reference model
//                expands each command into its expected per-cycle output
//                stream; directed and random commands are compared against it.
//                Honours RECT_BORDER_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_fill_engine;

  localparam int CD = 3;
  localparam int NX = 8;
  localparam int NY = 7;
`ifdef RECT_BORDER_EN
  localparam bit HAS_BORDER = 1'b1;
`else
  localparam bit HAS_BORDER = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [NX-1:0] x0;
  logic [NY-1:0] y0;
  logic [NX-1:0] w;
  logic [NY-1:0] h;
  logic [CD-1:0] color;
`ifdef RECT_BORDER_EN
  logic          border;
  logic [CD-1:0] border_color;
`endif
  logic          busy;
  logic          done;
  logic [NX-1:0] vga_x;
  logic [NY-1:0] vga_y;
  logic [CD-1:0] vga_color;
  logic          vga_plot;

  rect_fill_engine #(
    .COLOR_DEPTH(CD), .nX(NX), .nY(NY), .COLS(160), .ROWS(120)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .w           (w),
    .h           (h),
    .color       (color),
`ifdef RECT_BORDER_EN
    .border      (border),
    .border_color(border_color),
`endif
    .busy        (busy),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_color   (vga_color),
    .vga_plot    (vga_plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit plot;
    int x;
    int y;
    int c;
    bit busy;
    bit done;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: a command expands into w*h pixel cycles (raster order), then one
  // done cycle. Visibility and colour come straight from the pixel position.
  task automatic expect_cmd(input int cx0, input int cy0, input int cw, input int ch,
                            input int cc, input int cb, input int cbc);
    rec_t r;
    for (int j = 0; j < ch; j++) begin
      for (int i = 0; i < cw; i++) begin
        r.x    = cx0 + i;
        r.y    = cy0 + j;
        r.plot = (r.x < 160) && (r.y < 120);
        r.c    = (HAS_BORDER && cb != 0 &&
                  (i == 0 || i == cw - 1 || j == 0 || j == ch - 1)) ? cbc : cc;
        r.busy = 1'b1;
        r.done = 1'b0;
        exp_q.push_back(r);
      end
    end
    r.plot = 1'b0; r.x = 0; r.y = 0; r.c = 0; r.busy = 1'b0; r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic step_check();
    rec_t r;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL queue: observed=empty expected=entry");
    end else begin
      r = exp_q.pop_front();
      chk("busy", busy, r.busy);
      chk("done", done, r.done);
      chk("plot", vga_plot, r.plot);
      if (r.plot) begin
        chk("x", vga_x, r.x);
        chk("y", vga_y, r.y);
        chk("colour", vga_color, r.c);
      end
    end
  endtask

  task automatic set_cmd(input int cx0, input int cy0, input int cw, input int ch,
                         input int cc, input int cb, input int cbc);
    x0    = NX'(cx0);
    y0    = NY'(cy0);
    w     = NX'(cw);
    h     = NY'(ch);
    color = CD'(cc);
`ifdef RECT_BORDER_EN
    border       = 1'(cb);
    border_color = CD'(cbc);
`else
    if (cb != cbc) begin end
`endif
  endtask

  task automatic scramble();
    x0    = NX'($urandom);
    y0    = NY'($urandom);
    w     = NX'($urandom);
    h     = NY'($urandom);
    color = CD'($urandom);
`ifdef RECT_BORDER_EN
    border       = 1'($urandom);
    border_color = CD'($urandom);
`endif
  endtask

  // Issue one command and check its full output stream. With noise set,
  // inputs are scrambled after acceptance and start is toggled while busy.
  task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch,
                         input int cc, input int cb, input int cbc, input bit noise);
    set_cmd(cx0, cy0, cw, ch, cc, cb, cbc);
    start = 1'b1;
    expect_cmd(cx0, cy0, cw, ch, cc, cb, cbc);
    tick();
    start = 1'b0;
    if (noise) scramble();
    while (exp_q.size() > 0) begin
      bit bz;
      bz = exp_q[0].busy;
      step_check();
      start = (noise && bz) ? 1'($urandom) : 1'b0;
      if (noise) scramble();
      tick();
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_plot", vga_plot, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_color, 0);
    reset = 1'b0;
    tick();
    idle_check(2);

    // Basic fill
    run_cmd(10, 20, 3, 2, 5, 0, 0, 1'b0);
    // Clipping at the right/bottom edges
    run_cmd(158, 119, 4, 2, 7, 0, 0, 1'b0);
    // Empty rectangles
    run_cmd(30, 30, 0, 5, 3, 0, 0, 1'b0);
    run_cmd(30, 30, 5, 0, 3, 0, 0, 1'b0);
    idle_check(1);
    // Starts and input changes while busy must not disturb the stream
    run_cmd(40, 50, 5, 3, 2, 0, 0, 1'b1);

    // Back-to-back: second command accepted in the done cycle of a 1x1
    set_cmd(5, 5, 1, 1, 2, 0, 0);
    start = 1'b1;
    expect_cmd(5, 5, 1, 1, 2, 0, 0);
    tick();
    start = 1'b0;
    step_check();
    tick();
    step_check();
    set_cmd(7, 8, 1, 2, 4, 0, 0);
    start = 1'b1;
    expect_cmd(7, 8, 1, 2, 4, 0, 0);
    tick();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      step_check();
      tick();
    end

    // Reset at the third pixel of a 4x4 fill
    set_cmd(20, 30, 4, 4, 3, 0, 0);
    start = 1'b1;
    expect_cmd(20, 30, 4, 4, 3, 0, 0);
    tick();
    start = 1'b0;
    step_check();
    tick();
    step_check();
    tick();
    step_check();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_plot", vga_plot, 0);
    chk("abort_x", vga_x, 0);
    chk("abort_y", vga_y, 0);
    chk("abort_colour", vga_color, 0);
    idle_check(5);
    run_cmd(0, 0, 2, 2, 6, 0, 0, 1'b0);

`ifdef RECT_BORDER_EN
    run_cmd(50, 60, 3, 3, 1, 1, 6, 1'b0);
`endif

    // Random commands, including clipped, empty and bordered ones
    for (int n = 0; n < 30; n++) begin
      run_cmd(int'($urandom_range(0, 170)), int'($urandom_range(0, 125)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), 1'($urandom));
    end
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
